// File: rtl/debouncer_if.sv
// rtl/debouncer_if.sv - debouncer level/strobe bundle
interface debouncer_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic [DATA_WIDTH-1:0] o_rise;
  logic [DATA_WIDTH-1:0] o_fall;
  logic [DATA_WIDTH-1:0] o_busy;

  modport master (
    output i_data,
    input  o_data, o_rise, o_fall, o_busy
  );

  modport slave (
    input  i_data,
    output o_data, o_rise, o_fall, o_busy
  );
endinterface

// File: rtl/debouncer.sv
// rtl/debouncer.sv - per-bit glitch filter with rise/fall strobes
module debouncer #(
  parameter int                    DATA_WIDTH    = 1,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic         i_clock,
  input  logic         i_aresetn,
  debouncer_if.slave   bus
);

  localparam int CNT_W = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0]      cnt_q [DATA_WIDTH];
  logic [CNT_W-1:0]      cnt_d [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d;
  logic [DATA_WIDTH-1:0] fall_q, fall_d;
  logic [DATA_WIDTH-1:0] busy;

  // cnt counts consecutive samples that differ from the accepted level
  always_comb begin
    data_d = data_q;
    rise_d = '0;
    fall_d = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      cnt_d[b] = cnt_q[b];
      if (bus.i_data[b] == data_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        cnt_d[b]  = '0;
        data_d[b] = bus.i_data[b];
        rise_d[b] = bus.i_data[b];
        fall_d[b] = ~bus.i_data[b];
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      data_q <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      for (int b = 0; b < DATA_WIDTH; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int b = 0; b < DATA_WIDTH; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      busy[b] = (cnt_q[b] != '0);
    end
  end

  assign bus.o_data = data_q;
  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;
  assign bus.o_busy = busy;

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - randomized bench for debouncer against a sample-window model
module tb_debouncer;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  debouncer_if #(.DATA_WIDTH(4)) if_a ();
  debouncer_if #(.DATA_WIDTH(1)) if_b ();
  debouncer_if #(.DATA_WIDTH(2)) if_c ();

  debouncer #(.DATA_WIDTH(4), .STABLE_CYCLES(4), .RESET_VALUE(4'h0)) dut_a (
    .i_clock(clk), .i_aresetn(aresetn), .bus(if_a.slave));
  debouncer #(.DATA_WIDTH(1), .STABLE_CYCLES(1), .RESET_VALUE(1'b0)) dut_b (
    .i_clock(clk), .i_aresetn(aresetn), .bus(if_b.slave));
  debouncer #(.DATA_WIDTH(2), .STABLE_CYCLES(3), .RESET_VALUE(2'b10)) dut_c (
    .i_clock(clk), .i_aresetn(aresetn), .bus(if_c.slave));

  int n_cmp = 0;
  int n_fail = 0;

  int         nsc [3] = '{4, 1, 3};
  int         ndw [3] = '{4, 1, 2};
  logic [3:0] rv  [3] = '{4'h0, 4'h0, 4'h2};

  // Reference: a bit takes a new level once its last N samples all equal that level
  logic [3:0] m_out  [3];
  logic [3:0] m_rise [3];
  logic [3:0] m_fall [3];
  logic [3:0] m_busy [3];
  logic [3:0] m_hist [3][4];

  logic [3:0] od [3], orr [3], of [3], ob [3];
  assign od[0] = if_a.o_data;     assign orr[0] = if_a.o_rise;
  assign of[0] = if_a.o_fall;     assign ob[0]  = if_a.o_busy;
  assign od[1] = 4'(if_b.o_data); assign orr[1] = 4'(if_b.o_rise);
  assign of[1] = 4'(if_b.o_fall); assign ob[1]  = 4'(if_b.o_busy);
  assign od[2] = 4'(if_c.o_data); assign orr[2] = 4'(if_c.o_rise);
  assign of[2] = 4'(if_c.o_fall); assign ob[2]  = 4'(if_c.o_busy);

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_out[d] = rv[d];
      m_rise[d] = '0;
      m_fall[d] = '0;
      m_busy[d] = '0;
      for (int b = 0; b < 4; b++) m_hist[d][b] = {4{rv[d][b]}};
    end
  endfunction

  function automatic void model_step(int d, logic [3:0] in);
    logic [3:0] mask, win;
    mask = 4'((1 << nsc[d]) - 1);
    m_rise[d] = '0;
    m_fall[d] = '0;
    m_busy[d] = '0;
    for (int b = 0; b < ndw[d]; b++) begin
      m_hist[d][b] = {m_hist[d][b][2:0], in[b]};
      win = m_hist[d][b] & mask;
      if (!m_out[d][b] && win == mask) begin
        m_out[d][b] = 1'b1;
        m_rise[d][b] = 1'b1;
      end else if (m_out[d][b] && win == 4'h0) begin
        m_out[d][b] = 1'b0;
        m_fall[d][b] = 1'b1;
      end
      m_busy[d][b] = (in[b] != m_out[d][b]);
    end
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d_data", d), od[d],  m_out[d]);
      check($sformatf("dut%0d_rise", d), orr[d], m_rise[d]);
      check($sformatf("dut%0d_fall", d), of[d],  m_fall[d]);
      check($sformatf("dut%0d_busy", d), ob[d],  m_busy[d]);
    end
  endtask

  // Called just after a falling edge; applies inputs, steps one clock, checks at next falling edge
  task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    if_a.i_data = a;
    if_b.i_data = b[0:0];
    if_c.i_data = c[1:0];
    @(posedge clk);
    model_step(0, a);
    model_step(1, b);
    model_step(2, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic mid_reset();
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    aresetn = 1'b1;
  endtask

  logic [3:0] cur [3];
  int         hold [3];

  initial begin
    if_a.i_data = 4'h0;
    if_b.i_data = 1'b0;
    if_c.i_data = 2'b10;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    aresetn = 1'b1;

    // quiet input equal to reset value: no strobes on release
    cycle(4'h0, 4'h0, 4'h2);
    cycle(4'h0, 4'h0, 4'h2);
    // bits 0 and 3 rise together, bit 1 glitches for 2 cycles
    cycle(4'b1011, 4'h1, 4'h2);
    cycle(4'b1011, 4'h1, 4'h2);
    cycle(4'b1001, 4'h0, 4'h2);
    cycle(4'b1001, 4'h0, 4'h2);
    check("simul_rise", orr[0], 4'b1001);
    check("simul_data", od[0], 4'b1001);
    // bit 2: 1,1,0,1,1,1,1 ; dut_c bit1 falls after 3 zeros
    cycle(4'b1101, 4'h1, 4'h0);
    cycle(4'b1101, 4'h1, 4'h0);
    cycle(4'b1001, 4'h0, 4'h0);
    check("c_fall", of[2], 4'b0010);
    for (int i = 0; i < 4; i++) cycle(4'b1101, 4'h1, 4'h1);
    check("late_rise", orr[0], 4'b0100);
    // bit 3 falls, then reset during a qualification on dut_c
    for (int i = 0; i < 4; i++) cycle(4'b0101, 4'h0, 4'h0);
    check("a_fall", of[0], 4'b1000);
    cycle(4'b0101, 4'h0, 4'h2);
    cycle(4'b0101, 4'h0, 4'h2);
    mid_reset();
    check("reset_data_c", od[2], 4'h2);

    for (int d = 0; d < 3; d++) begin
      cur[d] = rv[d];
      hold[d] = 0;
    end
    for (int n = 0; n < 800; n++) begin
      for (int d = 0; d < 3; d++) begin
        if (hold[d] == 0) begin
          cur[d] = (cur[d] ^ 4'($urandom)) & 4'((1 << ndw[d]) - 1);
          hold[d] = $urandom_range(1, 6);
        end
        hold[d]--;
      end
      if (n % 197 == 150) mid_reset();
      cycle(cur[0], cur[1], cur[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Per-bit glitch filter placed directly downstream of the synchronizer in the same clock domain.
- Takes already-synchronized level signals, typically from switches, buttons or slow external status lines.
- Updates its filtered output only after an input has held a new value for STABLE_CYCLES consecutive clocks.
- Emits single-cycle rise/fall strobes on every accepted change, for use by control FSMs and interrupt logic.

Parameters:
- DATA_WIDTH, 1, number of independent channels; each bit is filtered separately.
- STABLE_CYCLES, 4, consecutive samples of a differing value required before the output accepts it; legal range >= 1.
- RESET_VALUE, '0 (DATA_WIDTH bits), value loaded into o_data on reset.

Ports:
- i_clock  input  1  clock; all state updates on rising edge.
- i_aresetn  input  1  reset, asynchronous, active-low.
- i_data  input  DATA_WIDTH  synchronized input levels; must already be in the i_clock domain.
- o_data  output  DATA_WIDTH  debounced levels.
- o_rise  output  DATA_WIDTH  1-cycle strobe per bit when o_data bit changes 0->1.
- o_fall  output  DATA_WIDTH  1-cycle strobe per bit when o_data bit changes 1->0.
- o_busy  output  DATA_WIDTH  per bit: 1 while a candidate change is being qualified (counter non-zero).

Behaviour:
- Reset (async assert, sync deassert by upstream reset logic):
  - o_data = RESET_VALUE.
  - o_rise = o_fall = o_busy = 0.
  - All counters = 0.
  - No strobes are generated by reset or by its release.
- Per-bit state: counter cnt of width $clog2(STABLE_CYCLES+1), min 1 bit. Two states per bit:
  - IDLE: cnt == 0.
  - QUALIFY: cnt != 0.
- At each rising edge, per bit b:
  - If i_data[b] == o_data[b]: cnt <= 0; stay/return to IDLE. An abandoned qualification produces no strobe.
  - If they differ and cnt == STABLE_CYCLES-1:
    - o_data[b] <= i_data[b], cnt <= 0.
    - o_rise[b] <= i_data[b].
    - o_fall[b] <= ~i_data[b].
  - If they differ otherwise: cnt <= cnt+1 (IDLE -> QUALIFY).
- Strobes are registered and deassert on the following edge unless another change is accepted, which is impossible before STABLE_CYCLES more edges.
- Latency: a new value first sampled at edge e1 and held through edge eN (N = STABLE_CYCLES) appears on o_data, with its strobe, immediately after eN.
- STABLE_CYCLES = 1: o_data is i_data delayed by one register; o_busy is always 0.
- A glitch of width < STABLE_CYCLES cycles never reaches o_data.
- Any sample equal to o_data during qualification restarts the count from zero on the next difference.
- The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- Bits are fully independent; simultaneous changes on several bits are each qualified and strobed in their own cycle.
- Reset asserted mid-qualification discards the count immediately and returns o_data to RESET_VALUE.
- Combinational i_data -> output paths: none.
- o_busy is derived from the cnt registers (cnt != 0).

Test Plan:
1. DATA_WIDTH=1, STABLE_CYCLES=4, reset released, i_data=0 → o_data=0, all strobes 0. Then i_data=1 held → o_data=1 after the 4th sampling edge; o_rise=1 for exactly 1 cycle; o_busy=1 for the 3 cycles before that.
2. Glitches: i_data=1 for 3 cycles then 0 → o_data stays 0, no o_rise, o_busy returns to 0. Pattern 1,1,0,1,1,1,1 → o_data rises only after the final 4 consecutive 1s.
3. Falling edge: o_data=1, i_data=0 held 4 cycles → o_data=0, o_fall single pulse, o_rise stays 0.
4. RESET_VALUE=1, i_data=1 at reset release → o_data=1 and no strobes. Assert i_aresetn low at cycle 2 of a 0-qualification → o_data=1, cnt cleared; after release, a fresh 4-cycle hold is needed.
5. DATA_WIDTH=4: bit0 and bit3 change in the same cycle, bit1 glitches for 2 cycles → o_rise=4'b1001 in one cycle; bit1 unchanged.
6. STABLE_CYCLES=1: random i_data → o_data equals i_data delayed 1 cycle; strobes match registered edges; o_busy always 0.
